// File: rtl/sid_audio_pkg.sv
// Shared widths, defaults and sample conversion for the SID audio I2S transmitter.
package sid_audio_pkg;

  localparam int AUDIO_W       = 16;
  localparam int IDX_W         = $clog2(AUDIO_W);
  localparam int I2S_CLK_DIV   = 8;
  localparam int I2S_SLOT_BITS = 32;
  localparam int FRAME_BITS    = 2 * I2S_SLOT_BITS;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // Offset-binary midscale 0x8000 becomes two's-complement zero.
  function automatic logic [AUDIO_W-1:0] offset_to_twos(input logic [AUDIO_W-1:0] s);
    return {~s[AUDIO_W-1], s[AUDIO_W-2:0]};
  endfunction

endpackage

// File: rtl/sid_i2s_clkgen.sv
// Divides clk_sys into the I2S bit clock and flags the cycle on which bclk falls.
module sid_i2s_clkgen
  import sid_audio_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV
) (
  input  logic clk_sys,
  input  logic clear,
  output logic bclk,
  output logic fall_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall_tick = wrap & bclk;

  always_ff @(posedge clk_sys) begin
    if (clear) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      bclk    <= bclk ^ wrap;
    end
  end

endmodule

// File: rtl/sid_audio_i2s_tx.sv
// Latches SID stereo PCM once per frame and shifts it out as Philips I2S.
module sid_audio_i2s_tx
  import sid_audio_pkg::*;
#(
  parameter int CLK_DIV    = I2S_CLK_DIV,
  parameter int SLOT_BITS  = I2S_SLOT_BITS,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               enable,
  input  logic               mute,
  input  logic [AUDIO_W-1:0] audio_l,
  input  logic [AUDIO_W-1:0] audio_r,
  output logic               i2s_bclk,
  output logic               i2s_lrclk,
  output logic               i2s_sd,
  output logic               sample_req
);

  localparam int FRAME_W = 2 * SLOT_BITS;
  localparam int BIT_W   = $clog2(FRAME_W);

  logic               clear;
  logic               fall_tick;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_next;
  logic [BIT_W-1:0]   slot_pos;
  logic [IDX_W-1:0]   bit_idx;
  logic [AUDIO_W-1:0] shadow_l;
  logic [AUDIO_W-1:0] shadow_r;
  logic [AUDIO_W-1:0] conv_l;
  logic [AUDIO_W-1:0] conv_r;
  logic [AUDIO_W-1:0] cur_sample;
  logic               sd_next;
  slot_e              slot_next;

  assign clear = rst | ~enable;

  sid_i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_sys   (clk_sys),
    .clear     (clear),
    .bclk      (i2s_bclk),
    .fall_tick (fall_tick)
  );

  assign conv_l = OFFSET_BIN ? offset_to_twos(audio_l) : audio_l;
  assign conv_r = OFFSET_BIN ? offset_to_twos(audio_r) : audio_r;

  // Everything below is computed from the bit position the next fall tick moves to.
  always_comb begin
    bit_next   = (bit_cnt == BIT_W'(FRAME_W - 1)) ? '0 : bit_cnt + 1'b1;
    slot_next  = (bit_next >= BIT_W'(SLOT_BITS)) ? SLOT_RIGHT : SLOT_LEFT;
    slot_pos   = (slot_next == SLOT_RIGHT) ? bit_next - BIT_W'(SLOT_BITS) : bit_next;
    cur_sample = (slot_next == SLOT_RIGHT) ? shadow_r : shadow_l;
    bit_idx    = IDX_W'(BIT_W'(AUDIO_W) - slot_pos);
    sd_next    = 1'b0;
    if (slot_pos != '0 && slot_pos <= BIT_W'(AUDIO_W)) begin
      sd_next = cur_sample[bit_idx];
    end
  end

  // Position 0 of the frame is the I2S delay bit, so the freshly latched
  // shadow words are not read until the following fall tick.
  always_ff @(posedge clk_sys) begin
    if (clear) begin
      bit_cnt    <= BIT_W'(FRAME_W - 1);
      i2s_lrclk  <= 1'b0;
      i2s_sd     <= 1'b0;
      sample_req <= 1'b0;
      shadow_l   <= '0;
      shadow_r   <= '0;
    end else begin
      sample_req <= 1'b0;
      if (fall_tick) begin
        bit_cnt   <= bit_next;
        i2s_lrclk <= slot_next;
        i2s_sd    <= sd_next;
        if (bit_next == '0) begin
          shadow_l   <= mute ? '0 : conv_l;
          shadow_r   <= mute ? '0 : conv_r;
          sample_req <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_audio_i2s_tx.sv
// Drives two transmitters (pass-through and offset-binary) and decodes their I2S streams.
module tb_sid_audio_i2s_tx;

  localparam int CD     = 2;
  localparam int SB     = 32;
  localparam int FR     = 2 * SB;
  localparam int PERIOD = 2 * CD * FR;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        enable  = 1'b0;
  logic        mute    = 1'b0;
  logic [15:0] audio_l = '0;
  logic [15:0] audio_r = '0;
  logic        bclk_w  [2];
  logic        lrclk_w [2];
  logic        sd_w    [2];
  logic        sreq_w  [2];

  int checks = 0;
  int errors = 0;

  int          cyc  = 0;
  bit          held = 1'b1;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  int          rx_p      [2];
  bit          rx_armed  [2];
  logic        rx_prev   [2];
  logic [15:0] rx_l      [2];
  logic [15:0] rx_r      [2];
  int          rx_frames [2];

  always #5 clk_sys = ~clk_sys;

  sid_audio_i2s_tx #(.CLK_DIV(CD), .SLOT_BITS(SB), .OFFSET_BIN(1'b0)) dut0 (
    .clk_sys(clk_sys), .rst(rst), .enable(enable), .mute(mute),
    .audio_l(audio_l), .audio_r(audio_r),
    .i2s_bclk(bclk_w[0]), .i2s_lrclk(lrclk_w[0]), .i2s_sd(sd_w[0]), .sample_req(sreq_w[0])
  );

  sid_audio_i2s_tx #(.CLK_DIV(CD), .SLOT_BITS(SB), .OFFSET_BIN(1'b1)) dut1 (
    .clk_sys(clk_sys), .rst(rst), .enable(enable), .mute(mute),
    .audio_l(audio_l), .audio_r(audio_r),
    .i2s_bclk(bclk_w[1]), .i2s_lrclk(lrclk_w[1]), .i2s_sd(sd_w[1]), .sample_req(sreq_w[1])
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] l, input logic [15:0] r, input logic m);
    @(negedge clk_sys);
    audio_l = l;
    audio_r = r;
    mute    = m;
  endtask

  task automatic wait_sample_req(output int waited);
    waited = 0;
    do begin
      @(negedge clk_sys);
      waited++;
    end while (!sreq_w[0] && waited < PERIOD + 50);
    if (!sreq_w[0]) check_output("sreq_timeout", 32'd0, 32'd1);
  endtask

  // Reference timing: c = clk_sys cycles since reset release.
  function automatic logic exp_bclk(input int c);
    return logic'((c / CD) % 2);
  endfunction

  function automatic logic exp_lrclk(input int c);
    if (c < 2 * CD) return 1'b0;
    return logic'(((c / (2 * CD)) - 1) % FR >= SB);
  endfunction

  function automatic logic is_latch(input int c);
    return logic'(c >= 2 * CD && c % (2 * CD) == 0 && ((c / (2 * CD)) - 1) % FR == 0);
  endfunction

  function automatic logic [15:0] model_conv(input logic [15:0] a, input bit offset_bin);
    return offset_bin ? 16'(a - 16'd32768) : a;
  endfunction

  // Reference model: tracks time since release and records what each frame must carry.
  always @(posedge clk_sys) begin
    if (rst || !enable) begin
      cyc  <= 0;
      held <= 1'b1;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      held <= 1'b0;
      cyc  <= cyc + 1;
      if (is_latch(cyc + 1)) begin
        exp_q0.push_back(mute ? 32'd0 : {model_conv(audio_l, 1'b0), model_conv(audio_r, 1'b0)});
        exp_q1.push_back(mute ? 32'd0 : {model_conv(audio_l, 1'b1), model_conv(audio_r, 1'b1)});
      end
    end
  end

  // Per-cycle waveform checks plus a bclk-rise I2S receiver for each DUT.
  always @(negedge clk_sys) begin
    logic [31:0] want;
    int          k;
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("bclk_dut%0d", d), {31'd0, bclk_w[d]}, {31'd0, exp_bclk(cyc)});
      check_output($sformatf("lrclk_dut%0d", d), {31'd0, lrclk_w[d]}, {31'd0, exp_lrclk(cyc)});
      check_output($sformatf("sreq_dut%0d", d), {31'd0, sreq_w[d]}, {31'd0, is_latch(cyc)});
      if (held) begin
        check_output($sformatf("sd_idle_dut%0d", d), {31'd0, sd_w[d]}, 32'd0);
        rx_armed[d] <= 1'b0;
        rx_prev[d]  <= 1'b0;
      end else begin
        if (sreq_w[d]) begin
          rx_armed[d] <= 1'b1;
          rx_p[d]     <= 0;
        end else if (bclk_w[d] && !rx_prev[d] && rx_armed[d]) begin
          k = rx_p[d] % SB;
          if (k >= 1 && k <= 16) begin
            if (rx_p[d] < SB) rx_l[d] <= {rx_l[d][14:0], sd_w[d]};
            else              rx_r[d] <= {rx_r[d][14:0], sd_w[d]};
          end else begin
            check_output($sformatf("pad_dut%0d_bit%0d", d, rx_p[d]), {31'd0, sd_w[d]}, 32'd0);
          end
          if (rx_p[d] == FR - 1) begin
            rx_armed[d]  <= 1'b0;
            rx_frames[d] <= rx_frames[d] + 1;
            if (d == 0) begin
              check_output("queue_dut0", {31'd0, exp_q0.size() != 0}, 32'd1);
              want = (exp_q0.size() != 0) ? exp_q0.pop_front() : 32'd0;
            end else begin
              check_output("queue_dut1", {31'd0, exp_q1.size() != 0}, 32'd1);
              want = (exp_q1.size() != 0) ? exp_q1.pop_front() : 32'd0;
            end
            check_output($sformatf("frame_dut%0d", d), {rx_l[d], rx_r[d]}, want);
          end
          rx_p[d] <= rx_p[d] + 1;
        end
        rx_prev[d] <= bclk_w[d];
      end
    end
  end

  initial begin
    int waited;
    for (int d = 0; d < 2; d++) begin
      rx_p[d] = 0; rx_armed[d] = 1'b0; rx_prev[d] = 1'b0;
      rx_l[d] = '0; rx_r[d] = '0; rx_frames[d] = 0;
    end

    // Reset, then held idle by enable=0.
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    repeat (100) @(negedge clk_sys);
    check_output("idle_bclk", {31'd0, bclk_w[0]}, 32'd0);

    // Basic frame and first-latch timing.
    apply_stimulus(16'hA5C3, 16'h0F0F, 1'b0);
    enable = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
    check_output("first_sreq", {31'd0, sreq_w[0]}, 32'd1);
    check_output("first_lrclk", {31'd0, lrclk_w[0]}, 32'd0);
    repeat (2 * PERIOD) @(negedge clk_sys);

    // Offset-binary midscale and full-negative codes.
    apply_stimulus(16'h8000, 16'h0000, 1'b0);
    repeat (2 * PERIOD) @(negedge clk_sys);

    // Mid-frame change is deferred to the next latch; also measure the period.
    apply_stimulus(16'h1234, 16'h4321, 1'b0);
    wait_sample_req(waited);
    repeat (5 * 2 * CD) @(negedge clk_sys);
    audio_l = 16'hFFFF;
    wait_sample_req(waited);
    wait_sample_req(waited);
    check_output("sreq_period", 32'(waited), 32'(PERIOD));

    // Mute, then unmute.
    apply_stimulus(16'h7FFF, 16'h7FFF, 1'b1);
    repeat (2 * PERIOD) @(negedge clk_sys);
    apply_stimulus(16'h7FFF, 16'h7FFF, 1'b0);
    repeat (2 * PERIOD) @(negedge clk_sys);

    // Random samples changed at random times, occasional mute.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(16'($urandom), 16'($urandom), ($urandom_range(0, 4) == 0));
      repeat ($urandom_range(60, 400)) @(negedge clk_sys);
    end
    apply_stimulus(16'h5A5A, 16'hC001, 1'b0);

    // Abort around right-slot bit 10, then re-enable.
    wait_sample_req(waited);
    repeat ((SB + 10) * 2 * CD + 1) @(negedge clk_sys);
    check_output("pre_abort_lrclk", {31'd0, lrclk_w[0]}, 32'd1);
    enable = 1'b0;
    @(negedge clk_sys);
    check_output("abort_bclk", {31'd0, bclk_w[0]}, 32'd0);
    check_output("abort_lrclk", {31'd0, lrclk_w[1]}, 32'd0);
    check_output("abort_sd", {31'd0, sd_w[0] | sd_w[1]}, 32'd0);
    repeat (20) @(negedge clk_sys);
    enable = 1'b1;
    repeat (2 * CD) @(posedge clk_sys);
    #1;
    check_output("reenable_sreq", {31'd0, sreq_w[0]}, 32'd1);
    check_output("reenable_lrclk", {31'd0, lrclk_w[0]}, 32'd0);
    repeat (2 * PERIOD + 20) @(negedge clk_sys);

    check_output("frames_dut0", {31'd0, rx_frames[0] >= 15}, 32'd1);
    check_output("frames_dut1", {31'd0, rx_frames[1] == rx_frames[0]}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sid_audio_i2s_tx.md
Name: sid_audio_i2s_tx

Overview:
Downstream of sid_emulation. Captures its 16-bit audio_l/audio_r PCM once per audio frame and serialises them as standard Philips I2S (BCLK, LRCLK, SD) for the board's external audio DAC. All timing is derived from clk_sys by an integer divider; no second clock domain.

Parameters:
CLK_DIV, 8, clk_sys cycles per BCLK half-period (min 2); 50 MHz / (2*8*64) = 48.83 kHz frame rate
SLOT_BITS, 32, BCLK cycles per channel slot (min 17); frame = 2*SLOT_BITS
OFFSET_BIN, 1, 1 = input is unsigned offset-binary, so invert bit 15 to get two's complement; 0 = pass through

Ports:
clk_sys  in  1  system clock
rst      in  1  synchronous reset, active-high
enable   in  1  0 = hold in reset state (synchronous), 1 = run
mute     in  1  sampled at frame latch; 1 forces both latched samples to 0
audio_l  in  16  left PCM from sid_emulation
audio_r  in  16  right PCM from sid_emulation
i2s_bclk  out  1  bit clock
i2s_lrclk out  1  word select, 0 = left, 1 = right
i2s_sd    out  1  serial data, MSB first
sample_req out 1  one-clk_sys pulse on the cycle audio_l/r are latched

Behaviour:
- Reset (rst=1 or enable=0, synchronous): div_cnt=0, bit_cnt=2*SLOT_BITS-1, bclk=0, lrclk=0, sd=0, sample_req=0, shadow_l=shadow_r=0. rst has priority over enable.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps; at the wrap cycle bclk toggles (registered). Rising edge = DAC sample point; all lrclk/sd updates occur only on the clk_sys cycle where bclk goes 1->0 (the "fall tick").
- Fall tick: bit_cnt <= (bit_cnt == 2*SLOT_BITS-1) ? 0 : bit_cnt+1. Outputs use the new bit_cnt value n:
  - lrclk <= (n >= SLOT_BITS).
  - sd: k = n mod SLOT_BITS; k=0 -> 0 (one-bit I2S delay); k=1..16 -> sample bit 16-k (k=1 is bit 15); k>=17 -> 0. Sample = shadow_l when n<SLOT_BITS, else shadow_r.
- Frame latch: on the fall tick where n becomes 0, shadow_l/shadow_r <= converted audio_l/audio_r (0 if mute), and sample_req=1 for that one cycle. Conversion: bit 15 inverted if OFFSET_BIN=1. Latched values are stable for the entire frame; input changes mid-frame are ignored.
- Timing after reset release (enable=1): first rising bclk at clk_sys cycle CLK_DIV, first fall tick (latch, n=0, lrclk=0) at cycle 2*CLK_DIV; left MSB on sd at fall tick 1 (cycle 4*CLK_DIV). Period: sample_req every 2*CLK_DIV*2*SLOT_BITS cycles exactly.
- Data path latency input->first sd bit: 1 BCLK after latch. No FIFO; the SID is a free-running source, so dropped or repeated samples are not a concern.
- mute/enable changes mid-frame: mute takes effect at the next latch; enable=0 aborts immediately to the reset state (partial frame discarded, lrclk/sd/bclk forced to 0).

Decomposition:
- Shared package sid_audio_pkg: AUDIO_W=16, I2S_SLOT_BITS default, localparam FRAME_BITS=2*SLOT_BITS, function for offset-binary -> two's-complement conversion.
- One natural sub-module: sid_i2s_clkgen (div_cnt, bclk, fall/rise tick strobes); serialiser and latch stay in the top module.

Test Plan:
- Reset/idle: rst=1 for 5 cycles, then enable=0 for 100 cycles -> bclk=lrclk=sd=sample_req=0 throughout.
- Basic frame: CLK_DIV=2, SLOT_BITS=32, OFFSET_BIN=0, audio_l=16'hA5C3, audio_r=16'h0F0F -> sample_req at cycle 4; receiver samples on bclk rise decode L=A5C3, R=0F0F; bits 17..31 of each slot =0; lrclk low for 32 BCLKs, high for 32.
- Offset conversion: OFFSET_BIN=1, audio_l=16'h8000, audio_r=16'h0000 -> decoded L=16'h0000, R=16'h8000.
- Mid-frame change: latch audio_l=16'h1234, change to 16'hFFFF at bit 5 -> this frame decodes 1234, next frame FFFF; sample_req period = 256 cycles (CLK_DIV=2).
- Mute: mute=1 before a latch with audio_l=audio_r=16'h7FFF -> frame decodes 0/0; mute deasserted -> following frame 7FFF/7FFF.
- Abort: enable=0 at right-slot bit 10, then re-enabled -> outputs 0 immediately; after re-enable, first sample_req after exactly 2*CLK_DIV cycles, lrclk=0.
